// File: rtl/thor2024_fetch_pc_gen_pkg.sv
// Thor2024 front-end shared types: fetch PC, fetch-queue entry, fetch FSM.
// Also holds the sequential fetch step shared with the BTB.
package thor2024_fetch_pc_gen_pkg;

  localparam int PC_W = 32;

  typedef logic [PC_W-1:0] pc_address_t;

  localparam pc_address_t THOR_FETCH_STEP = 32'h0000_A000;

  typedef struct packed {
    logic        takb;
    pc_address_t pc;
    pc_address_t tgt;
  } fq_entry_t;

  typedef enum logic [1:0] {
    REDIR = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_t;

  // Next sequential group; low 12 bits cleared, wraps modulo 2^PC_W.
  function automatic pc_address_t seq_pc_f(
    input pc_address_t cur,
    input pc_address_t step
  );
    pc_address_t s;
    s = cur + step;
    return {s[PC_W-1:12], 12'h000};
  endfunction

endpackage

// File: rtl/thor2024_fetch_fifo.sv
// Circular in-order fetch queue of fq_entry_t with push/pop/flush.
// Ports: rclk, rst, push, pop, flush, din -> dout (head), full, empty.
module thor2024_fetch_fifo
  import thor2024_fetch_pc_gen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      rclk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t din,
  output fq_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [AW:0]     cnt;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rptr];

  // A pop that coincides with a flush is dropped; flush wins.
  always_ff @(posedge rclk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/thor2024_fetch_pc_gen.sv
// Fetch PC generator: next-PC mux, fetch FSM and fetch queue to decode.
// Ports: rclk/rst, ihit, btb_*, redirect*, pc out, fq_* handshake to decoder.
module thor2024_fetch_pc_gen
  import thor2024_fetch_pc_gen_pkg::*;
#(
  parameter pc_address_t RESET_PC   = 32'hFFFD_0000,
  parameter pc_address_t FETCH_STEP = THOR_FETCH_STEP,
  parameter int          FQ_DEPTH   = 4
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        ihit,
  input  logic        btb_takb,
  input  pc_address_t btb_next_pc,
  input  logic        redirect,
  input  pc_address_t redirect_pc,
  output pc_address_t pc,
  output logic        fq_valid,
  input  logic        fq_ready,
  output pc_address_t fq_pc,
  output logic        fq_takb,
  output pc_address_t fq_tgt
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic         accept;
  logic         pop;
  logic         space;
  logic         fq_full;
  logic         fq_empty;
  pc_address_t  seq_pc;
  pc_address_t  next_pc;
  fq_entry_t    wr_ent;
  fq_entry_t    rd_ent;

  assign seq_pc  = seq_pc_f(pc, FETCH_STEP);
  assign next_pc = btb_takb ? btb_next_pc : seq_pc;

  assign fq_valid = !fq_empty;
  assign pop      = fq_valid & fq_ready;
  // A same-cycle pop frees the slot the push needs.
  assign space    = !fq_full | pop;

  always_ff @(posedge rclk) begin
    if (rst)
      state_q <= REDIR;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = REDIR;
    end else begin
      case (state_q)
        REDIR:   state_d = RUN;
        RUN:     if (!(ihit && space)) state_d = STALL;
        STALL:   if (ihit && space) state_d = RUN;
        default: state_d = REDIR;
      endcase
    end
  end

  // REDIR is the BTB read bubble; STALL may accept on its exit cycle.
  always_comb begin
    accept = 1'b0;
    case (state_q)
      RUN,
      STALL:   accept = ihit & space & !redirect;
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect)
      pc <= redirect_pc;
    else if (accept)
      pc <= next_pc;
  end

  assign wr_ent = '{takb: btb_takb, pc: pc, tgt: next_pc};

  thor2024_fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .rclk  (rclk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .flush (redirect),
    .din   (wr_ent),
    .dout  (rd_ent),
    .full  (fq_full),
    .empty (fq_empty)
  );

  assign fq_pc   = rd_ent.pc;
  assign fq_takb = rd_ent.takb;
  assign fq_tgt  = rd_ent.tgt;

endmodule

// File: tb/tb_thor2024_fetch_pc_gen.sv
// Bench for thor2024_fetch_pc_gen: directed plan then random stimulus
// against a queue-based reference model.
module tb_thor2024_fetch_pc_gen;
  import thor2024_fetch_pc_gen_pkg::*;

  localparam pc_address_t RST_PC = 32'hFFFD_0000;
  localparam pc_address_t STEP   = 32'h0000_A000;
  localparam int          DEPTH  = 4;

  logic        rclk;
  logic        rst;
  logic        ihit;
  logic        btb_takb;
  pc_address_t btb_next_pc;
  logic        redirect;
  pc_address_t redirect_pc;
  pc_address_t pc;
  logic        fq_valid;
  logic        fq_ready;
  pc_address_t fq_pc;
  logic        fq_takb;
  pc_address_t fq_tgt;

  int checks   = 0;
  int failures = 0;

  pc_address_t m_pc;
  bit          m_bub;
  fq_entry_t   m_q[$];

  thor2024_fetch_pc_gen #(
    .RESET_PC   (RST_PC),
    .FETCH_STEP (STEP),
    .FQ_DEPTH   (DEPTH)
  ) dut (
    .rclk        (rclk),
    .rst         (rst),
    .ihit        (ihit),
    .btb_takb    (btb_takb),
    .btb_next_pc (btb_next_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .fq_valid    (fq_valid),
    .fq_ready    (fq_ready),
    .fq_pc       (fq_pc),
    .fq_takb     (fq_takb),
    .fq_tgt      (fq_tgt)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive, compare, clock, update model.
  task automatic step(input bit r, input bit ih, input bit tk,
                      input pc_address_t tg, input bit rd,
                      input pc_address_t rp, input bit fr);
    bit          pop;
    bit          acc;
    pc_address_t nxt;
    pc_address_t mask;
    fq_entry_t   e;
    rst         = r;
    ihit        = ih;
    btb_takb    = tk;
    btb_next_pc = tg;
    redirect    = rd;
    redirect_pc = rp;
    fq_ready    = fr;
    #1;
    chk("pc", pc, m_pc);
    chk("fq_valid", 32'(fq_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("fq_pc", fq_pc, m_q[0].pc);
      chk("fq_takb", 32'(fq_takb), 32'(m_q[0].takb));
      chk("fq_tgt", fq_tgt, m_q[0].tgt);
    end
    mask = 32'h0000_0FFF;
    nxt  = tk ? tg : ((m_pc + STEP) & ~mask);
    pop  = (m_q.size() != 0) && fr;
    acc  = !r && !rd && !m_bub && ih && ((m_q.size() < DEPTH) || pop);
    e    = '{takb: tk, pc: m_pc, tgt: nxt};
    @(posedge rclk);
    if (r) begin
      m_pc  = RST_PC;
      m_bub = 1'b1;
      m_q.delete();
    end else if (rd) begin
      m_pc  = rp;
      m_bub = 1'b1;
      m_q.delete();
    end else begin
      m_bub = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(e);
        m_pc = nxt;
      end
    end
    @(negedge rclk);
  endtask

  initial begin
    rst = 1'b1; ihit = 1'b0; btb_takb = 1'b0; btb_next_pc = '0;
    redirect = 1'b0; redirect_pc = '0; fq_ready = 1'b0;
    m_pc = RST_PC; m_bub = 1'b1;
    @(negedge rclk);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'hFFFD_0000);
    chk("rst_valid", 32'(fq_valid), 0);
    chk("rst_fq_pc", fq_pc, 0);
    chk("rst_fq_takb", 32'(fq_takb), 0);
    chk("rst_fq_tgt", fq_tgt, 0);

    step(0, 1, 0, 0, 0, 0, 1);
    chk("bubble_pc", pc, 32'hFFFD_0000);
    chk("bubble_valid", 32'(fq_valid), 0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("seq_pc1", pc, 32'hFFFD_A000);
    chk("seq_fq_pc", fq_pc, 32'hFFFD_0000);
    chk("seq_fq_takb", 32'(fq_takb), 0);
    step(0, 1, 1, 32'h1234_0000, 0, 0, 1);
    chk("tk_pc", pc, 32'h1234_0000);
    chk("tk_fq_pc", fq_pc, 32'hFFFD_A000);
    chk("tk_fq_takb", 32'(fq_takb), 1);
    chk("tk_fq_tgt", fq_tgt, 32'h1234_0000);

    step(0, 1, 0, 0, 1, 32'hFFFE_4000, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("ihit0_pc", pc, 32'hFFFE_4000);
    chk("ihit0_valid", 32'(fq_valid), 0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("ihit1_pc", pc, 32'hFFFE_E000);

    step(0, 1, 0, 0, 1, 32'h0001_0000, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 0);
    chk("full_pc", pc, 32'h0003_8000);
    chk("full_head", fq_pc, 32'h0001_0000);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("poppush_pc", pc, 32'h0004_2000);
    chk("poppush_head", fq_pc, 32'h0001_A000);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("full2_pc", pc, 32'h0004_2000);

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 32'h0050_0000, 1);
    chk("redir_pc", pc, 32'h0050_0000);
    chk("redir_valid", 32'(fq_valid), 0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("redir_bub_pc", pc, 32'h0050_0000);
    chk("redir_bub_valid", 32'(fq_valid), 0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("redir_push_pc", pc, 32'h0050_A000);
    chk("redir_push_head", fq_pc, 32'h0050_0000);

    step(0, 1, 0, 0, 1, 32'hFFFF_F000, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("wrap_pc", pc, 32'h0000_9000);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0,
           pc_address_t'($urandom()),
           $urandom_range(0, 15) == 0,
           pc_address_t'($urandom()),
           $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thor2024_fetch_pc_gen.md
# thor2024_fetch_pc_gen

Fetch-address generator and fetch queue for the Thor2024 front end. It owns the architectural fetch PC and drives it to the BTB and the instruction cache. It selects the next PC from the BTB prediction, a sequential increment, or a back-end redirect. Each accepted fetch group's PC and prediction are recorded in a small in-order queue that the decoder drains with a valid/ready handshake.

## Interface
Parameters:
- RESET_PC, 'hFFFD0000: fetch PC loaded on reset.
- FETCH_STEP, 'hA000: sequential fetch-group increment, applied to the full pc_address_t.
- FQ_DEPTH, 4: fetch-queue entries; power of two, at least 2.

Ports:
- rclk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ihit  in  1  icache has the group at `pc` this cycle.
- btb_takb  in  1  BTB predicts taken for `pc`.
- btb_next_pc  in  pc_address_t  BTB predicted target.
- redirect  in  1  back-end misprediction or exception redirect.
- redirect_pc  in  pc_address_t  redirect destination.
- pc  out  pc_address_t  current fetch PC, registered, to the BTB and the icache.
- fq_valid  out  1  queue head valid.
- fq_ready  in  1  decoder accepts the head.
- fq_pc  out  pc_address_t  head fetch PC.
- fq_takb  out  1  head predicted-taken flag.
- fq_tgt  out  pc_address_t  head predicted next PC.

## Operation
- Sequential next PC is seq_pc = pc + FETCH_STEP with bits [11:0] forced to 0. The addition is modulo 2^$bits(pc_address_t), so it wraps silently.
- Next PC is btb_takb ? btb_next_pc : seq_pc. btb_next_pc is ignored when btb_takb is 0.
- A group is accepted when state is RUN, ihit is 1, redirect is 0, and the queue is not full or a pop occurs in the same cycle.
- On accept: push {pc, btb_takb, next PC} and load pc with next PC.
- Pop occurs when fq_valid and fq_ready are both 1.
- State machine with states REDIR, RUN and STALL:
  - REDIR: one-cycle bubble covering the BTB's registered read. No accept. Always goes to RUN.
  - RUN: accept when possible. Go to STALL when ihit is 0 or the queue is full without a pop.
  - STALL: pc held. Return to RUN on the cycle ihit is 1 and there is space; accept is evaluated in that same cycle.
  - From any state, redirect loads pc with redirect_pc, flushes the queue, and enters REDIR.
- Priority: rst > redirect > accept > hold.
- Queue: circular buffer with read and write pointers of log2(FQ_DEPTH) bits and a count of log2(FQ_DEPTH)+1 bits. Full when count equals FQ_DEPTH; empty when count is 0.
- Push and pop in the same cycle leave the count unchanged. This is legal when full, because the pop frees the slot first.
- Flush zeroes both pointers and the count. A pop presented in the same cycle as a flush is discarded.

## Timing
- Reset values:
  - pc = RESET_PC.
  - state = REDIR.
  - fq_valid = 0; fq_pc, fq_takb and fq_tgt = 0.
  - Pointers and count = 0.
- The first accept is possible in the 2nd cycle after rst deasserts.
- pc updates one cycle after accept or redirect. The BTB sees the new pc in that same cycle.
- A pushed entry appears on fq_* the cycle after the push. There is no same-cycle bypass.
- fq_* are driven from storage at the read pointer, so they are stable while fq_valid=1 and fq_ready=0.
- After a redirect, fq_valid is 0 in the next cycle and no push occurs for one further cycle (REDIR).
- rst asserted mid-stall or mid-redirect has the same effect as cold reset; the queue is emptied.
- Steady-state throughput is one group per cycle with ihit held at 1 and fq_ready held at 1.

## Structure
- Thor2024pkg:
  - pc_address_t (existing).
  - New typedef fq_entry_t {takb, pc, tgt}.
  - New enum fetch_state_t {REDIR, RUN, STALL}.
  - FETCH_STEP constant shared with the BTB's sequential path.
- Sub-module thor2024_fetch_fifo: a parameterised circular FIFO of fq_entry_t with push, pop, flush, full, empty and count.
- The top level holds the pc register, the state machine and the next-PC mux.

## Test plan
- Reset then ihit=1, btb_takb=0, fq_ready=1 -> pc sequence FFFD0000, FFFDA000, FFFE4000; fq_pc follows one cycle later with fq_takb=0.
- btb_takb=1 with btb_next_pc=12340000 at pc=FFFDA000 -> next pc=12340000; the queue entry is {FFFDA000, 1, 12340000}.
- fq_ready=0 with ihit=1 -> exactly 4 pushes, then pc holds and state is STALL. Raise fq_ready for one cycle -> one pop and one push in that cycle, count stays 4.
- ihit=0 for 3 cycles at pc=FFFE4000 -> pc holds and there are no pushes. ihit returns to 1 -> accepted in that cycle, pc=FFFEE000 next.
- redirect=1 with redirect_pc=00500000 while the queue holds 3 entries and fq_ready=1 -> next cycle pc=00500000 and fq_valid=0. The first push happens in the cycle after that.
- pc=FFFFF000 with ihit=1 and btb_takb=0 -> next pc=00009000, confirming wrap-around and the cleared low 12 bits.
